// File: rtl/fft_bfly_stage_if.sv
// rtl/fft_bfly_stage_if.sv - vector handshake bundle for the butterfly stage
// Carries the input vector (din_i/din_q/scale_in), input handshake
// (in_valid/in_ready), output vector (do_re/do_im) and output handshake
// (out_valid/out_ready). slave = stage view, master = upstream/downstream view.
interface fft_bfly_stage_if #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = IN_WIDTH + 1,
    parameter int NUM       = 16
);
    logic signed [IN_WIDTH-1:0]  din_i [0:NUM-1];
    logic signed [IN_WIDTH-1:0]  din_q [0:NUM-1];
    logic                        scale_in;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_WIDTH-1:0] do_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do_im [0:NUM-1];
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  din_i, din_q, scale_in, in_valid, out_ready,
        output in_ready, do_re, do_im, out_valid
    );

    modport master (
        output din_i, din_q, scale_in, in_valid, out_ready,
        input  in_ready, do_re, do_im, out_valid
    );
endinterface

// File: rtl/fft_bfly_stage.sv
// rtl/fft_bfly_stage.sv - radix-2 butterfly stage with -j twiddle and 2-entry output FIFO
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fft_bfly_stage_if.slave: din_i/din_q/scale_in/in_valid/in_ready in,
//          do_re/do_im/out_valid/out_ready out
// Build option: BFLY_ROUND_EN selects round-half-up halving; otherwise floor.
module fft_bfly_stage #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = IN_WIDTH + 1,
    parameter int NUM       = 16,
    parameter int SPAN      = 4,
    parameter int TW_J      = 1
) (
    input  logic             clk,
    input  logic             rst,
    fft_bfly_stage_if.slave  bus
);

    function automatic logic signed [OUT_WIDTH-1:0] sx(input logic signed [IN_WIDTH-1:0] x);
        return {{(OUT_WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    endfunction

    // Halving keeps OUT_WIDTH; the rounding add is done one bit wider because
    // a difference lane can reach +(2^IN_WIDTH - 1) and +1 would wrap.
    function automatic logic signed [OUT_WIDTH-1:0] half(input logic signed [OUT_WIDTH-1:0] x);
`ifdef BFLY_ROUND_EN
        logic signed [OUT_WIDTH:0] t;
        t = {x[OUT_WIDTH-1], x} + {{OUT_WIDTH{1'b0}}, 1'b1};
        return t[OUT_WIDTH:1];
`else
        return {x[OUT_WIDTH-1], x[OUT_WIDTH-1:1]};
`endif
    endfunction

    logic signed [OUT_WIDTH-1:0] res_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] res_im [0:NUM-1];

    logic signed [OUT_WIDTH-1:0] buf_re_q [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] buf_im_q [0:1][0:NUM-1];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       in_ready_w, push, pop, tail;

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        localparam int K = g % (2 * SPAN);
        logic signed [OUT_WIDTH-1:0] raw_re, raw_im;

        if (K < SPAN) begin : g_sum
            assign raw_re = sx(bus.din_i[g]) + sx(bus.din_i[g+SPAN]);
            assign raw_im = sx(bus.din_q[g]) + sx(bus.din_q[g+SPAN]);
        end else begin : g_diff
            logic signed [OUT_WIDTH-1:0] dr, dq;
            assign dr = sx(bus.din_i[g-SPAN]) - sx(bus.din_i[g]);
            assign dq = sx(bus.din_q[g-SPAN]) - sx(bus.din_q[g]);
            // Upper quarter of the group gets the trivial -j rotation.
            if (TW_J != 0 && K >= SPAN + SPAN / 2) begin : g_twj
                assign raw_re = dq;
                assign raw_im = -dr;
            end else begin : g_plain
                assign raw_re = dr;
                assign raw_im = dq;
            end
        end

        assign res_re[g] = bus.scale_in ? half(raw_re) : raw_re;
        assign res_im[g] = bus.scale_in ? half(raw_im) : raw_im;

        assign bus.do_re[g] = buf_re_q[head_q][g];
        assign bus.do_im[g] = buf_im_q[head_q][g];
    end

    // in_ready depends only on registered count (and rst), never on out_ready.
    assign in_ready_w    = !rst && (count_q != 2'd2);
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && in_ready_w;
    assign pop           = bus.out_valid && bus.out_ready;
    // Tail slot is the one after head when one entry is already occupied.
    assign tail          = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        case ({push, pop})
            2'b10: count_d = count_q + 2'd1;
            2'b01: begin
                count_d = count_q - 2'd1;
                head_d  = ~head_q;
            end
            2'b11: head_d = ~head_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                for (int l = 0; l < NUM; l++) begin
                    buf_re_q[e][l] <= '0;
                    buf_im_q[e][l] <= '0;
                end
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push) begin
                for (int l = 0; l < NUM; l++) begin
                    buf_re_q[tail][l] <= res_re[l];
                    buf_im_q[tail][l] <= res_im[l];
                end
            end
        end
    end

endmodule
